udi_pow_seq_ctl: RTL and testbench

//  Sequencer for the UDI square/threshold unit with ONE shared 16x16 unsigned multiplier. Squares RS[31:16]

---
 rtl/udi_pow_seq_ctl.sv | 175 +++++++++++++++++
 tb/tb_udi_pow_seq_ctl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/udi_pow_seq_ctl.sv
// Square/threshold sequencer for the UDI unit: one shared 16x16 multiplier squares RS then RT,
// accumulates, and finishes with sum/shift/bypass/compare. Optional build macro: UDI_POW_SAT_EN (saturating SUM).
module udi_pow_seq_ctl #(
    parameter logic [31:0] THR_RST = 32'h0
) (
    input  logic        UDI_gclk,
    input  logic        UDI_greset,
    input  logic        UDI_gscanenable,
    input  logic        start_e,
    input  logic [2:0]  func_e,
    input  logic [15:0] rs_hi_e,
    input  logic [15:0] rt_hi_e,
    input  logic [31:0] thr_wdata_e,
    input  logic        run_m,
    input  logic        kill_m,
    output logic        stall_m,
    output logic [31:0] rd_m,
    output logic        rd_valid_m,
    output logic        busy,
    output logic [31:0] thr_q
);

    localparam logic [2:0] F_SUM    = 3'd0;
    localparam logic [2:0] F_SUMSHR = 3'd1;
    localparam logic [2:0] F_THRWR  = 3'd3;
    localparam logic [2:0] F_CMPSUM = 3'd4;
    localparam logic [2:0] F_CMPSHR = 3'd5;
    localparam logic [2:0] F_INVAL  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL_RS = 3'd1,
        S_MUL_RT = 3'd2,
        S_FIN    = 3'd3,
        S_THR    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  func_q, func_d;
    logic [15:0] rs_q, rs_d;
    logic [15:0] rt_q, rt_d;
    logic [31:0] thr_wd_q, thr_wd_d;
    logic [32:0] acc_q, acc_d;
    logic [31:0] thr_d;
    logic        stall_q, stall_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_q, rd_d;
    logic        busy_q, busy_d;

    logic [15:0] mul_op;
    logic [31:0] product;
    logic        kill_first;
    logic        accept;
    logic        two_sq;
    logic        unused_scan;

    assign unused_scan = UDI_gscanenable;

    // The single multiplier is time-shared: RS in MUL_RS, RT in MUL_RT.
    assign mul_op  = (state_q == S_MUL_RT) ? rt_q : rs_q;
    assign product = 32'(mul_op) * 32'(mul_op);

    assign kill_first = kill_m & run_m;
    assign two_sq     = (func_q == F_SUM)    || (func_q == F_SUMSHR) ||
                        (func_q == F_CMPSUM) || (func_q == F_CMPSHR);

    function automatic logic [31:0] calc_rd(input logic [2:0]  f,
                                            input logic [32:0] acc,
                                            input logic [31:0] thr);
        logic [31:0] v;
        v = acc[31:0];
        if (f == F_SUMSHR || f == F_CMPSHR) begin
            v = acc[32:1];
        end
`ifdef UDI_POW_SAT_EN
        else if ((f == F_SUM || f == F_CMPSUM) && acc[32]) begin
            v = 32'hFFFF_FFFF;
        end
`endif
        // funct[2] set marks the compare family (4,5,6); 7 is never latched.
        if (f[2]) begin
            calc_rd = {31'b0, v > thr};
        end else begin
            calc_rd = v;
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        thr_wd_d = thr_wd_q;
        acc_d    = acc_q;
        thr_d    = thr_q;
        accept   = 1'b0;

        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                accept  = start_e && (func_e != F_INVAL);
            end
            S_THR: begin
                state_d = S_IDLE;
                if (!kill_first) begin
                    thr_d  = thr_wd_q;
                    accept = start_e && (func_e != F_INVAL);
                end
            end
            S_MUL_RS: begin
                if (kill_first) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = {1'b0, product};
                    state_d = two_sq ? S_MUL_RT : S_FIN;
                end
            end
            S_MUL_RT: begin
                acc_d   = acc_q + {1'b0, product};
                state_d = S_FIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            func_d   = func_e;
            rs_d     = rs_hi_e;
            rt_d     = rt_hi_e;
            thr_wd_d = thr_wdata_e;
            state_d  = (func_e == F_THRWR) ? S_THR : S_MUL_RS;
        end

        // Outputs are registered decodes of the next state, so they carry no input-to-output path.
        stall_d    = (state_d == S_MUL_RS) || (state_d == S_MUL_RT);
        rd_valid_d = (state_d == S_FIN);
        busy_d     = (state_d != S_IDLE);
        rd_d       = (state_d == S_FIN) ? calc_rd(func_q, acc_d, thr_q) : 32'h0;
    end

    always_ff @(posedge UDI_gclk) begin
        if (UDI_greset) begin
            state_q    <= S_IDLE;
            func_q     <= 3'd0;
            rs_q       <= 16'h0;
            rt_q       <= 16'h0;
            thr_wd_q   <= 32'h0;
            acc_q      <= 33'h0;
            thr_q      <= THR_RST;
            stall_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_q       <= 32'h0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            func_q     <= func_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            thr_wd_q   <= thr_wd_d;
            acc_q      <= acc_d;
            thr_q      <= thr_d;
            stall_q    <= stall_d;
            rd_valid_q <= rd_valid_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
        end
    end

    assign stall_m    = stall_q;
    assign rd_valid_m = rd_valid_q;
    assign rd_m       = rd_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_udi_pow_seq_ctl.sv
// Bench for udi_pow_seq_ctl: directed steps then random ops, checked against an arithmetic model.
// Valid/ready: start_e is offered only when the unit is idle, finishing, or in THR.
module tb_udi_pow_seq_ctl;

    logic        clk;
    logic        UDI_greset;
    logic        UDI_gscanenable;
    logic        start_e;
    logic [2:0]  func_e;
    logic [15:0] rs_hi_e;
    logic [15:0] rt_hi_e;
    logic [31:0] thr_wdata_e;
    logic        run_m;
    logic        kill_m;
    logic        stall_m;
    logic [31:0] rd_m;
    logic        rd_valid_m;
    logic        busy;
    logic [31:0] thr_q;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] thr_model;
    bit          thr_pend;
    logic [31:0] thr_pend_val;

    udi_pow_seq_ctl #(.THR_RST(32'h0)) dut (
        .UDI_gclk(clk),
        .UDI_greset(UDI_greset),
        .UDI_gscanenable(UDI_gscanenable),
        .start_e(start_e),
        .func_e(func_e),
        .rs_hi_e(rs_hi_e),
        .rt_hi_e(rt_hi_e),
        .thr_wdata_e(thr_wdata_e),
        .run_m(run_m),
        .kill_m(kill_m),
        .stall_m(stall_m),
        .rd_m(rd_m),
        .rd_valid_m(rd_valid_m),
        .busy(busy),
        .thr_q(thr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        kill_m = 1'b0;
        run_m  = 1'b1;
        if (thr_pend) begin
            thr_model = thr_pend_val;
            thr_pend  = 1'b0;
        end
    endtask

    function automatic bit is_two(input logic [2:0] f);
        return (f == 3'd0) || (f == 3'd1) || (f == 3'd4) || (f == 3'd5);
    endfunction

    // Value before any compare, from plain integer arithmetic.
    function automatic logic [31:0] model_val(input logic [2:0] f, input logic [15:0] rs,
                                              input logic [15:0] rt);
        longint a, b, s;
        a = longint'(rs);
        b = longint'(rt);
        s = a * a;
        if (is_two(f)) s = s + b * b;
        if (f == 3'd1 || f == 3'd5) return 32'(s / 2);
        if ((f == 3'd0 || f == 3'd4) && s > 64'hFFFF_FFFF) begin
`ifdef UDI_POW_SAT_EN
            return 32'hFFFF_FFFF;
`else
            return 32'(s % 64'h1_0000_0000);
`endif
        end
        return 32'(s);
    endfunction

    task automatic drive_start(input logic [2:0] f, input logic [15:0] rs, input logic [15:0] rt,
                               input logic [31:0] wd);
        start_e     = 1'b1;
        func_e      = f;
        rs_hi_e     = rs;
        rt_hi_e     = rt;
        thr_wdata_e = wd;
    endtask

    // Full op; returns in the FIN (or THR) cycle so a following call is back-to-back.
    task automatic do_op(input logic [2:0] f, input logic [15:0] rs, input logic [15:0] rt,
                         input logic [31:0] wd, input bit kill_norun);
        int          n;
        logic [31:0] e;
        chk("thr_pre", thr_q, thr_model);
        drive_start(f, rs, rt, wd);
        if (f != 3'd3) exp_q.push_back(model_val(f, rs, rt));
        tick();
        start_e = 1'b0;
        if (kill_norun) begin
            kill_m = 1'b1;
            run_m  = 1'b0;
        end
        n = (f == 3'd3) ? 1 : (is_two(f) ? 3 : 2);
        for (int k = 1; k <= n; k++) begin
            chk($sformatf("stall f%0d c%0d", f, k), 32'(stall_m), 32'((f != 3'd3) && (k < n)));
            chk($sformatf("rdv f%0d c%0d", f, k), 32'(rd_valid_m), 32'((f != 3'd3) && (k == n)));
            chk($sformatf("busy f%0d c%0d", f, k), 32'(busy), 32'd1);
            if (k == n && f != 3'd3) begin
                e = exp_q.pop_front();
                if (f[2]) e = 32'(e > thr_model);
                chk($sformatf("rd f%0d rs=%h rt=%h", f, rs, rt), rd_m, e);
            end
            if (k < n) tick();
        end
        if (f == 3'd3) begin
            thr_pend     = 1'b1;
            thr_pend_val = wd;
        end
    endtask

    task automatic kill_op(input logic [2:0] f, input logic [15:0] rs, input logic [15:0] rt,
                           input logic [31:0] wd);
        chk("kill thr_pre", thr_q, thr_model);
        drive_start(f, rs, rt, wd);
        tick();
        start_e = 1'b0;
        kill_m  = 1'b1;
        run_m   = 1'b1;
        chk("kill first stall", 32'(stall_m), 32'(f != 3'd3));
        tick();
        chk("kill stall", 32'(stall_m), 32'd0);
        chk("kill rdv", 32'(rd_valid_m), 32'd0);
        chk("kill busy", 32'(busy), 32'd0);
        chk("kill thr", thr_q, thr_model);
    endtask

    task automatic idle(input int n);
        start_e = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        UDI_greset = 1'b1; UDI_gscanenable = 1'b0; start_e = 1'b0; func_e = 3'd0;
        rs_hi_e = 16'h0; rt_hi_e = 16'h0; thr_wdata_e = 32'h0; run_m = 1'b1; kill_m = 1'b0;
        thr_model = 32'h0; thr_pend = 1'b0; thr_pend_val = 32'h0;

        repeat (3) tick();
        chk("rst stall", 32'(stall_m), 32'd0);
        chk("rst rdv", 32'(rd_valid_m), 32'd0);
        chk("rst rd", rd_m, 32'd0);
        chk("rst thr", thr_q, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        UDI_greset = 1'b0;
        idle(1);

        do_op(3'd0, 16'h0003, 16'h0004, 32'h0, 1'b0);
        chk("sum 3,4 literal", rd_m, 32'd25);
        idle(1);
        do_op(3'd3, 16'h0, 16'h0, 32'h18, 1'b0);
        do_op(3'd4, 16'h0003, 16'h0004, 32'h0, 1'b0);
        chk("cmpsum 25>24", rd_m, 32'd1);
        do_op(3'd3, 16'h0, 16'h0, 32'h19, 1'b0);
        do_op(3'd4, 16'h0003, 16'h0004, 32'h0, 1'b0);
        chk("cmpsum 25>25", rd_m, 32'd0);
        do_op(3'd6, 16'h0005, 16'h0, 32'h0, 1'b0);
        chk("cmpsq 25>25", rd_m, 32'd0);
        idle(1);

        do_op(3'd1, 16'hFFFF, 16'hFFFF, 32'h0, 1'b0);
        chk("sumshr max", rd_m, 32'hFFFE_0001);
        do_op(3'd0, 16'hFFFF, 16'hFFFF, 32'h0, 1'b0);
`ifdef UDI_POW_SAT_EN
        chk("sum max sat", rd_m, 32'hFFFF_FFFF);
`else
        chk("sum max wrap", rd_m, 32'hFFFC_0002);
`endif
        idle(1);

        kill_op(3'd0, 16'h0007, 16'h0009, 32'h0);
        kill_op(3'd3, 16'h0, 16'h0, 32'hDEAD_BEEF);
        idle(1);
        chk("thr after kill", thr_q, 32'h19);
        do_op(3'd5, 16'h0010, 16'h0020, 32'h0, 1'b1);

        drive_start(3'd0, 16'h1234, 16'h4321, 32'h0);
        tick();
        start_e = 1'b0;
        tick();
        UDI_greset = 1'b1;
        tick();
        UDI_greset = 1'b0;
        thr_model  = 32'h0;
        chk("midrst stall", 32'(stall_m), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst rdv", 32'(rd_valid_m), 32'd0);
        chk("midrst thr", thr_q, 32'd0);
        tick();
        chk("midrst no result", 32'(rd_valid_m), 32'd0);

        do_op(3'd0, 16'h0100, 16'h0200, 32'h0, 1'b0);
        do_op(3'd2, 16'h0ABC, 16'h0, 32'h0, 1'b0);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [15:0] rs, rt;
            logic [31:0] wd;
            int          mode;
            f    = 3'($urandom_range(0, 6));
            rs   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            rt   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            wd   = $urandom;
            mode = $urandom_range(0, 5);
            if (mode == 0) kill_op(f, rs, rt, wd);
            else do_op(f, rs, rt, wd, mode == 1);
            idle($urandom_range(0, 2));
        end
        idle(2);
        chk("final thr", thr_q, thr_model);
        chk("exp_q drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
